// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Output stage behind the PE matrix. Realigns column-skewed result rows
//   (column j arrives j cycles after column 0), buffers whole rows in a small
//   FIFO and writes them row-major, one word per granted cycle, starting at
//   the C base address.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle job start; latches addr_c and n
//   addr_c, n         base address of C, active matrix size (clamped to N)
//   in_valid          column 0 of a new result row is valid this cycle
//   result_col        per-column PE outputs, column j valid j cycles later
//   mem_grant         memory port available this cycle
//   mem_write/addr/data  registered single-word write port
//   busy, done        job active, one-cycle completion pulse
//   overflow          sticky: a row was dropped because the FIFO was full
//   rows_written      rows fully written in the current job
module systolic_result_drain #(
  parameter int unsigned N      = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         addr_c,
  input  logic [3:0]                n,
  input  logic                      in_valid,
  input  logic [N-1:0][WIDTH-1:0]   result_col,
  input  logic                      mem_grant,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WIDTH-1:0]          mem_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [3:0]                rows_written
);

  localparam int unsigned CW    = 4;
  localparam int unsigned CI_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          base;
  logic [CW-1:0]              nn;
  logic [CW-1:0]              rows_in;
  logic [CW-1:0]              rows_pushed;
  logic [CW-1:0]              col;
  logic [N-2:0]               vpipe;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [N-1:0][WIDTH-1:0]    fifo_mem [DEPTH];
  logic                       last_wr;

  wire  [N-1:0][WIDTH-1:0]    aligned;
  logic [N-1:0][WIDTH-1:0]    head;
  logic [CW-1:0]              n_clamped;
  logic                       accept;
  logic                       push_req;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       issue;
  logic                       pop;
  logic                       push_ok;
  logic                       drop;
  logic                       last_pop;
  logic [ADDR_W-1:0]          wr_addr;

  // Deskew: column j is delayed N-1-j cycles so all columns line up with
  // the last column; the last column is used straight from the input.
  assign aligned[N-1] = result_col[N-1];

  for (genvar j = 0; j < N - 1; j++) begin : g_skew
    localparam int unsigned L = N - 1 - j;
    logic [WIDTH-1:0] dly [L];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < L; k++) dly[k] <= '0;
      end else begin
        dly[0] <= result_col[j];
        for (int k = 1; k < L; k++) dly[k] <= dly[k-1];
      end
    end

    assign aligned[j] = dly[L-1];
  end

  // Job / FIFO control terms
  assign n_clamped  = (n > CW'(N)) ? CW'(N) : n;
  assign accept     = in_valid && (state == RUN) && (rows_in < nn);
  assign push_req   = vpipe[N-2];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign issue      = (state == RUN) && !fifo_empty && mem_grant;
  assign pop        = issue && (col == CW'(nn - CW'(1)));
  // A pop in the same cycle frees the slot even when full.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  // Last row: every row has arrived and been pushed or dropped, and this pop
  // drains the final pushed row.
  assign last_pop   = pop && (rows_in == nn) && (vpipe == '0) &&
                      (CW'(rows_written + CW'(1)) == rows_pushed);
  assign head       = fifo_mem[rd_ptr];
  assign wr_addr    = base + ADDR_W'(rows_written) * ADDR_W'(nn) + ADDR_W'(col);

  // Row storage (pointers and occupancy live in the control block)
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= aligned;
  end

  // Control FSM, counters, FIFO pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      nn           <= '0;
      rows_in      <= '0;
      rows_pushed  <= '0;
      col          <= '0;
      vpipe        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_wr      <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      rows_written <= '0;
    end else begin
      done      <= 1'b0;
      mem_write <= issue;
      last_wr   <= last_pop;

      vpipe[0] <= accept;
      for (int k = 1; k < N - 1; k++) vpipe[k] <= vpipe[k-1];

      if (accept) rows_in <= rows_in + CW'(1);

      if (issue) begin
        mem_addr <= wr_addr;
        mem_data <= head[col[CI_W-1:0]];
        col      <= pop ? '0 : col + CW'(1);
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        rows_written <= rows_written + CW'(1);
      end

      if (push_ok) begin
        wr_ptr      <= wr_ptr + PW'(1);
        rows_pushed <= rows_pushed + CW'(1);
      end

      if (drop) overflow <= 1'b1;

      count <= count + CNT_W'(push_ok) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            base         <= addr_c;
            nn           <= n_clamped;
            rows_in      <= '0;
            rows_pushed  <= '0;
            rows_written <= '0;
            col          <= '0;
            busy         <= 1'b1;
            if (n_clamped == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // last_wr marks the cycle the final word is on the port
          if (last_wr) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Testbench for systolic_result_drain: scoreboard of expected (addr, data)
// writes filled as rows are driven, drained as the DUT writes.
// dut uses DEPTH=4; dut2 uses DEPTH=2 for the FIFO-overflow scenario.
module tb_systolic_result_drain;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 12;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  start2;
  logic [AW-1:0]         addr_c;
  logic [3:0]            n_sz;
  logic                  in_valid;
  logic [N-1:0][W-1:0]   result_col;
  logic                  mem_grant = 1'b0;

  logic                  mem_write, busy, done, overflow;
  logic [AW-1:0]         mem_addr;
  logic [W-1:0]          mem_data;
  logic [3:0]            rows_written;

  logic                  mem_write_2, busy_2, done_2, overflow_2;
  logic [AW-1:0]         mem_addr_2;
  logic [W-1:0]          mem_data_2;
  logic [3:0]            rows_written_2;

  exp_t q[$];
  exp_t q2[$];
  exp_t e1, e2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int gmode = 0;
  int n_wr = 0;
  int n_wr2 = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int t0 = 0;
  logic grant_q = 1'b0;

  systolic_result_drain #(.N(N), .WIDTH(W), .ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_c(addr_c), .n(n_sz),
    .in_valid(in_valid), .result_col(result_col), .mem_grant(mem_grant),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .overflow(overflow), .rows_written(rows_written)
  );

  systolic_result_drain #(.N(N), .WIDTH(W), .ADDR_W(AW), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .addr_c(addr_c), .n(n_sz),
    .in_valid(in_valid), .result_col(result_col), .mem_grant(mem_grant),
    .mem_write(mem_write_2), .mem_addr(mem_addr_2), .mem_data(mem_data_2),
    .busy(busy_2), .done(done_2), .overflow(overflow_2),
    .rows_written(rows_written_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    grant_q <= mem_grant;
  end

  // Grant pattern: 0 = always on, 1 = toggle every cycle, 2 = held off
  always @(negedge clk) begin
    case (gmode)
      0:       mem_grant = 1'b1;
      1:       mem_grant = ~mem_grant;
      default: mem_grant = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitors: each strobe must follow a granted cycle and match the queue head
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (n_wr == 0) first_wr_cyc = cyc;
      n_wr++;
      last_wr_cyc = cyc;
      check("wr_granted", 32'(grant_q), 32'd1);
      if (q.size() == 0) begin
        check("wr_extra", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e1 = q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e1.a));
        check("wr_data", 32'(mem_data), 32'(e1.d));
      end
    end
  end

  always @(negedge clk) begin
    if (mem_write_2 === 1'b1) begin
      n_wr2++;
      check("wr2_granted", 32'(grant_q), 32'd1);
      if (q2.size() == 0) begin
        check("wr2_extra", 32'(mem_addr_2), 32'hFFFF_FFFF);
      end else begin
        e2 = q2.pop_front();
        check("wr2_addr", 32'(mem_addr_2), 32'(e2.a));
        check("wr2_data", 32'(mem_data_2), 32'(e2.d));
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] a, input logic [3:0] nv, input bit second);
    @(negedge clk);
    addr_c = a;
    n_sz   = nv;
    if (second) start2 = 1'b1;
    else        start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Drive rows back-to-back with column skew; rows below keep_rows are
  // expected to be written (first nn_exp columns only).
  task automatic drive_rows(input int rows, input int nn_exp, input int base_a,
                            input int voff, input int keep_rows, input bit second);
    exp_t x;
    for (int c = 0; c < rows + int'(N) - 1; c++) begin
      @(negedge clk);
      if (c == 0) t0 = cyc;
      in_valid = (c < rows);
      for (int j = 0; j < int'(N); j++) begin
        int r;
        r = c - j;
        if (r >= 0 && r < rows) result_col[j] = W'(voff + r * 10 + j);
        else                    result_col[j] = 16'hBEEF;
      end
      if (c < rows && c < keep_rows) begin
        for (int j = 0; j < nn_exp; j++) begin
          x.a = AW'(base_a + c * nn_exp + j);
          x.d = W'(voff + c * 10 + j);
          if (second) q2.push_back(x);
          else        q.push_back(x);
        end
      end
    end
    @(negedge clk);
    in_valid   = 1'b0;
    result_col = '0;
  endtask

  task automatic wait_done(input bit second, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      #1;
      if ((second ? done_2 : done) === 1'b1) begin
        found    = 1'b1;
        done_cyc = cyc;
      end
    end
    check(second ? "done2_seen" : "done_seen", 32'(found), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; addr_c = '0; n_sz = '0;
    in_valid = 1'b0; result_col = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rows_written", 32'(rows_written), 32'd0);
    rst = 1'b0;

    // Full 4x4, grant always on
    gmode = 0;
    start_job(12'h100, 4'd4, 1'b0);
    n_wr = 0;
    drive_rows(4, 4, 'h100, 0, 4, 1'b0);
    wait_done(1'b0, 100);
    check("t1_writes", 32'(n_wr), 32'd16);
    check("t1_q_empty", 32'(q.size()), 32'd0);
    check("t1_rows_written", 32'(rows_written), 32'd4);
    check("t1_first_latency", 32'(first_wr_cyc), 32'(t0 + int'(N) + 1));
    check("t1_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));
    check("t1_busy_at_done", 32'(busy), 32'd1);
    check("t1_overflow", 32'(overflow), 32'd0);

    // n=2, 4-wide rows, plus one surplus row that must be ignored
    start_job(12'h200, 4'd2, 1'b0);
    n_wr = 0;
    drive_rows(3, 2, 'h200, 100, 2, 1'b0);
    wait_done(1'b0, 100);
    check("t2_writes", 32'(n_wr), 32'd4);
    check("t2_q_empty", 32'(q.size()), 32'd0);
    check("t2_rows_written", 32'(rows_written), 32'd2);

    // Toggled grant
    gmode = 1;
    start_job(12'h300, 4'd4, 1'b0);
    n_wr = 0;
    drive_rows(4, 4, 'h300, 200, 4, 1'b0);
    wait_done(1'b0, 200);
    check("t3_writes", 32'(n_wr), 32'd16);
    check("t3_q_empty", 32'(q.size()), 32'd0);
    check("t3_overflow", 32'(overflow), 32'd0);
    gmode = 0;

    // Address wrap-around
    start_job(12'hFFE, 4'd2, 1'b0);
    n_wr = 0;
    drive_rows(2, 2, 'hFFE, 300, 2, 1'b0);
    wait_done(1'b0, 100);
    check("t4_writes", 32'(n_wr), 32'd4);
    check("t4_q_empty", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-job after 5 writes
    start_job(12'h500, 4'd4, 1'b0);
    n_wr = 0;
    drive_rows(4, 4, 'h500, 400, 4, 1'b0);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        if (n_wr >= 5) hit = 1'b1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      check("t5_five_writes", 32'(n_wr), 32'd5);
    end
    #1 rst = 1'b1;
    #1;
    check("arst_mem_write", 32'(mem_write), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_data", 32'(mem_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_rows_written", 32'(rows_written), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_wr = 0;

    // n=0: done the cycle after start, no writes
    start_job(12'h040, 4'd0, 1'b0);
    #1;
    check("n0_done", 32'(done), 32'd1);
    check("n0_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("n0_writes", 32'(n_wr), 32'd0);
    check("n0_done_low", 32'(done), 32'd0);
    check("n0_busy_low", 32'(busy), 32'd0);

    // DEPTH=2 instance: grant held off until all rows arrive
    gmode = 2;
    start_job(12'h400, 4'd4, 1'b1);
    n_wr2 = 0;
    drive_rows(4, 4, 'h400, 500, 2, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("ovf_set", 32'(overflow_2), 32'd1);
    check("ovf_no_writes_yet", 32'(n_wr2), 32'd0);
    gmode = 0;
    wait_done(1'b1, 100);
    check("ovf_writes", 32'(n_wr2), 32'd8);
    check("ovf_q_empty", 32'(q2.size()), 32'd0);
    check("ovf_rows_written", 32'(rows_written_2), 32'd2);
    check("ovf_sticky", 32'(overflow_2), 32'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
